// File: rtl/pc_sequencer.sv
// IF-stage program counter: boots to RESET_VECTOR, steps by STEP, buffers redirects seen during a stall.
// Define PC_SEQ_MISALIGN_EN to send misaligned redirect targets to TRAP_VECTOR instead.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            BUSYWAIT,
    input  logic            FLUSH_EN,
    input  logic [XLEN-1:0] FLUSH_TARGET,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS_STEP,
    output logic            PC_VALID,
    output logic            REDIRECT_PENDING,
    output logic            MISALIGN_TRAP,
    output logic [1:0]      STATE_DBG
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

    state_t          state;
    logic [XLEN-1:0] pending;
    logic [XLEN-1:0] sel_target;
    logic [XLEN-1:0] commit_target;
    logic            commit_misalign;

    // Stall/redirect contract: BUSYWAIT is a level stall (1 = PC holds this edge);
    // FLUSH_EN is a one-cycle request sampled on every edge outside BOOT. A request seen
    // while stalled is kept in a single pending slot (latest wins) and committed on the
    // first unstalled edge, where a fresh FLUSH_EN on that same edge takes priority.
    assign sel_target = (state == HOLD && !FLUSH_EN) ? pending : FLUSH_TARGET;

`ifdef PC_SEQ_MISALIGN_EN
    assign commit_misalign = (sel_target[1:0] != 2'b00);
`else
    assign commit_misalign = 1'b0;
`endif

    assign commit_target = commit_misalign ? TRAP_VECTOR : sel_target;
    assign PC_PLUS_STEP  = PC + STEP_W;
    assign STATE_DBG     = state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= BOOT;
            PC               <= RESET_VECTOR;
            PC_VALID         <= 1'b0;
            pending          <= '0;
            REDIRECT_PENDING <= 1'b0;
            MISALIGN_TRAP    <= 1'b0;
        end else begin
            MISALIGN_TRAP <= 1'b0;
            case (state)
                // One-cycle bubble so the first valid fetch is RESET_VECTOR itself.
                BOOT: begin
                    state    <= RUN;
                    PC_VALID <= 1'b1;
                end
                RUN: begin
                    if (BUSYWAIT) begin
                        if (FLUSH_EN) begin
                            pending          <= FLUSH_TARGET;
                            REDIRECT_PENDING <= 1'b1;
                            state            <= HOLD;
                        end
                    end else if (FLUSH_EN) begin
                        PC            <= commit_target;
                        MISALIGN_TRAP <= commit_misalign;
                    end else begin
                        PC <= PC_PLUS_STEP;
                    end
                end
                HOLD: begin
                    if (BUSYWAIT) begin
                        if (FLUSH_EN) begin
                            pending <= FLUSH_TARGET;
                        end
                    end else begin
                        PC               <= commit_target;
                        MISALIGN_TRAP    <= commit_misalign;
                        REDIRECT_PENDING <= 1'b0;
                        state            <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a rule-level model.
// Expectations follow PC_SEQ_MISALIGN_EN when the bench is compiled with it defined.
module tb_pc_sequencer;

    logic        CLK;
    logic        RESET;
    logic        BUSYWAIT;
    logic        FLUSH_EN;
    logic [31:0] FLUSH_TARGET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS_STEP;
    logic        PC_VALID;
    logic        REDIRECT_PENDING;
    logic        MISALIGN_TRAP;
    logic [1:0]  STATE_DBG;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: fetch address, whether a fetch has been issued, an optional saved redirect.
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_has_pend;
    logic [31:0] m_pend_val;
    bit          m_trap;
    logic [31:0] exp_q[$];

    pc_sequencer dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .BUSYWAIT         (BUSYWAIT),
        .FLUSH_EN         (FLUSH_EN),
        .FLUSH_TARGET     (FLUSH_TARGET),
        .PC               (PC),
        .PC_PLUS_STEP     (PC_PLUS_STEP),
        .PC_VALID         (PC_VALID),
        .REDIRECT_PENDING (REDIRECT_PENDING),
        .MISALIGN_TRAP    (MISALIGN_TRAP),
        .STATE_DBG        (STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pc       = 32'h0;
        m_valid    = 0;
        m_has_pend = 0;
        m_pend_val = 32'h0;
        m_trap     = 0;
    endtask

    task automatic model_commit(input logic [31:0] t);
`ifdef PC_SEQ_MISALIGN_EN
        if (t % 4 != 0) begin
            m_pc   = 32'h0000_0100;
            m_trap = 1;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t;
`endif
    endtask

    // Applies the behavioural rules for one rising edge with reset released.
    task automatic model_edge(input logic b, input logic f, input logic [31:0] t);
        m_trap = 0;
        if (!m_valid) begin
            m_valid = 1;
        end else if (b) begin
            if (f) begin
                m_has_pend = 1;
                m_pend_val = t;
            end
        end else begin
            if (f) model_commit(t);
            else if (m_has_pend) model_commit(m_pend_val);
            else m_pc = m_pc + 32'd4;
            m_has_pend = 0;
        end
    endtask

    // ---------------- driver ----------------
    // Called away from an edge: drive inputs, take one rising edge, then sample point (#1 after).
    task automatic step(input logic b, input logic f, input logic [31:0] t);
        BUSYWAIT     = b;
        FLUSH_EN     = f;
        FLUSH_TARGET = t;
        @(posedge CLK);
        model_edge(b, f, t);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESET = 1'b0; BUSYWAIT = 1'b0; FLUSH_EN = 1'b0; FLUSH_TARGET = 32'h0;
        repeat (3) @(negedge CLK);
        model_reset();
        n_checks++;
        if (PC !== 32'h0 || PC_VALID !== 1'b0 || REDIRECT_PENDING !== 1'b0 || MISALIGN_TRAP !== 1'b0)
            $display("FAIL reset_state: pc=%h valid=%b rp=%b trap=%b expected pc=0 valid=0 rp=0 trap=0",
                     PC, PC_VALID, REDIRECT_PENDING, MISALIGN_TRAP);
        else n_pass++;
        n_checks++;
        if (PC_PLUS_STEP !== 32'h4) $display("FAIL reset_pc_plus: got %h expected 00000004", PC_PLUS_STEP);
        else n_pass++;
        RESET = 1'b1;
        #1;
        n_checks++;
        if (PC_VALID !== 1'b0 || PC !== 32'h0) $display("FAIL boot_bubble: valid=%b pc=%h expected valid=0 pc=0", PC_VALID, PC);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h0000_0ABC);  // stall/redirect during BOOT must be ignored
            if (i == 0) begin
                n_checks++;
                if (PC_VALID !== 1'b1 || PC !== 32'h0 || REDIRECT_PENDING !== 1'b0)
                    $display("FAIL boot_first: valid=%b pc=%h rp=%b expected valid=1 pc=0 rp=0", PC_VALID, PC, REDIRECT_PENDING);
                else n_pass++;
                BUSYWAIT = 1'b0; FLUSH_EN = 1'b0;
                break;
            end
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h4) $display("FAIL seq_pc4: got %h expected 00000004", PC); else n_pass++;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h8) $display("FAIL seq_pc8: got %h expected 00000008", PC); else n_pass++;
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h10) $display("FAIL run_to_10: got %h expected 00000010", PC); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0);
            n_checks++;
            if (PC !== 32'h10 || REDIRECT_PENDING !== 1'b0)
                $display("FAIL stall_hold: cycle %0d pc=%h rp=%b expected pc=00000010 rp=0", i, PC, REDIRECT_PENDING);
            else n_pass++;
        end
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h14) $display("FAIL stall_release: got %h expected 00000014", PC); else n_pass++;
    endtask

    task automatic test_pending();
        step(1'b0, 1'b1, 32'h20);
        n_checks++;
        if (PC !== 32'h20) $display("FAIL redirect_20: got %h expected 00000020", PC); else n_pass++;
        step(1'b1, 1'b1, 32'h80);
        step(1'b1, 1'b1, 32'h90);
        n_checks++;
        if (PC !== 32'h20 || REDIRECT_PENDING !== 1'b1)
            $display("FAIL pend_hold: pc=%h rp=%b expected pc=00000020 rp=1", PC, REDIRECT_PENDING);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h90 || REDIRECT_PENDING !== 1'b0)
            $display("FAIL pend_commit: pc=%h rp=%b expected pc=00000090 rp=0", PC, REDIRECT_PENDING);
        else n_pass++;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h94) $display("FAIL pend_after: got %h expected 00000094", PC); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b1, 32'h300);
        n_checks++;
        if (PC !== 32'h300) $display("FAIL b2b_redirect: got %h expected 00000300", PC); else n_pass++;
        step(1'b1, 1'b1, 32'h400);
        step(1'b0, 1'b1, 32'h500);  // fresh redirect on the release edge beats the pending one
        n_checks++;
        if (PC !== 32'h500 || REDIRECT_PENDING !== 1'b0)
            $display("FAIL release_flush: pc=%h rp=%b expected pc=00000500 rp=0", PC, REDIRECT_PENDING);
        else n_pass++;
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        n_checks++;
        if (PC !== 32'hFFFF_FFFC || PC_PLUS_STEP !== 32'h0)
            $display("FAIL wrap_top: pc=%h plus=%h expected pc=fffffffc plus=00000000", PC, PC_PLUS_STEP);
        else n_pass++;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h0 || PC_PLUS_STEP !== 32'h4)
            $display("FAIL wrap_zero: pc=%h plus=%h expected pc=00000000 plus=00000004", PC, PC_PLUS_STEP);
        else n_pass++;
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_trap;
`ifdef PC_SEQ_MISALIGN_EN
        exp_pc = 32'h100; exp_trap = 1'b1;
`else
        exp_pc = 32'h102; exp_trap = 1'b0;
`endif
        step(1'b0, 1'b1, 32'h102);
        n_checks++;
        if (PC !== exp_pc || MISALIGN_TRAP !== exp_trap)
            $display("FAIL misalign_direct: pc=%h trap=%b expected pc=%h trap=%b", PC, MISALIGN_TRAP, exp_pc, exp_trap);
        else n_pass++;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== exp_pc + 32'd4 || MISALIGN_TRAP !== 1'b0)
            $display("FAIL misalign_after: pc=%h trap=%b expected pc=%h trap=0", PC, MISALIGN_TRAP, exp_pc + 32'd4);
        else n_pass++;
        step(1'b1, 1'b1, 32'h203);
        step(1'b1, 1'b1, 32'h208);
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h208 || MISALIGN_TRAP !== 1'b0)
            $display("FAIL misalign_overwritten: pc=%h trap=%b expected pc=00000208 trap=0", PC, MISALIGN_TRAP);
        else n_pass++;
`ifndef PC_SEQ_MISALIGN_EN
        exp_pc = 32'h301;
`endif
        step(1'b1, 1'b1, 32'h301);
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== exp_pc || MISALIGN_TRAP !== exp_trap)
            $display("FAIL misalign_pending: pc=%h trap=%b expected pc=%h trap=%b", PC, MISALIGN_TRAP, exp_pc, exp_trap);
        else n_pass++;
    endtask

    task automatic test_reset_hold();
        step(1'b1, 1'b1, 32'h40);
        n_checks++;
        if (REDIRECT_PENDING !== 1'b1) $display("FAIL hold_entry: rp=%b expected 1", REDIRECT_PENDING); else n_pass++;
        #3;
        RESET = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (PC !== 32'h0 || REDIRECT_PENDING !== 1'b0 || PC_VALID !== 1'b0)
            $display("FAIL async_reset: pc=%h rp=%b valid=%b expected pc=0 rp=0 valid=0", PC, REDIRECT_PENDING, PC_VALID);
        else n_pass++;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC_VALID !== 1'b1 || PC !== 32'h0 || REDIRECT_PENDING !== 1'b0)
            $display("FAIL reboot_bubble: valid=%b pc=%h rp=%b expected valid=1 pc=0 rp=0", PC_VALID, PC, REDIRECT_PENDING);
        else n_pass++;
        step(1'b0, 1'b0, 32'h0);
        n_checks++;
        if (PC !== 32'h4) $display("FAIL reboot_step: got %h expected 00000004", PC); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] t;
        logic [31:0] want;
        int          errs = 0;
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), t);
            exp_q.push_back(m_pc);
            want = exp_q.pop_front();
            n_checks++;
            if (PC !== want || PC_PLUS_STEP !== want + 32'd4 || PC_VALID !== m_valid ||
                REDIRECT_PENDING !== m_has_pend || MISALIGN_TRAP !== m_trap) begin
                if (errs < 10)
                    $display("FAIL random cycle %0d: pc=%h plus=%h valid=%b rp=%b trap=%b expected pc=%h plus=%h valid=%b rp=%b trap=%b",
                             i, PC, PC_PLUS_STEP, PC_VALID, REDIRECT_PENDING, MISALIGN_TRAP,
                             want, want + 32'd4, m_valid, m_has_pend, m_trap);
                errs++;
            end else n_pass++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_stall();
        test_pending();
        test_back_to_back();
        test_wrap();
        test_misalign();
        test_reset_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
